rob_commit_unit: RTL
====================

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 Parameter DEPTH, default 16, ROB entries; SHALL be a power of two, at least 4.
REQ-002 Parameter IDX_W, default 4, tag width; SHALL equal log2(DEPTH).
REQ-003 Parameter XLEN, default 32, data width.
REQ-004 Port clock  in  1  rising-edge clock.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port alloc_valid  in  1  issue requests one entry this cycle.
REQ-007 Port alloc_dest  in  5  architectural destination register of the issuing instruction.
REQ-008 Port alloc_ready  out  1  entry available (count < DEPTH).
REQ-009 Port alloc_tag  out  IDX_W  tag given to the next allocation (current tail index).
REQ-010 Port cdb_valid  in  1  CDB broadcast valid.
REQ-011 Port cdb_tag  in  IDX_W  ROB tag of the broadcast result.
REQ-012 Port cdb_value  in  XLEN  result value.
REQ-013 Port rd_tag  in  IDX_W  operand-lookup tag from issue.
REQ-014 Port rd_ready  out  1  looked-up entry is busy and has its value.
REQ-015 Port rd_value  out  XLEN  looked-up entry value.
REQ-016 Port commit_valid  out  1  one-cycle pulse per retired instruction.
REQ-017 Port commit_dest, commit_tag, commit_value  out  5/IDX_W/XLEN  retired entry fields, for ARF write and RAT tag clear.
REQ-018 Port flush  in  1  discard all entries (mispredict/exception).
REQ-019 Port count  out  IDX_W+1  occupied entries.

Function
REQ-020 Storage per entry SHALL be: busy, done, dest[4:0], value[XLEN-1:0]; circular buffer with head, tail (IDX_W bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-021 Allocate when alloc_valid && alloc_ready: at the edge, entry[tail] gets busy=1, done=0, dest=alloc_dest; tail+1; count+1.
REQ-022 alloc_valid while alloc_ready=0 SHALL be ignored with no state change; full blocks allocation even when a commit occurs in the same cycle (no bypass).
REQ-023 CDB write when cdb_valid and entry[cdb_tag].busy: value=cdb_value, done=1 at the edge; a broadcast to a non-busy entry SHALL be ignored.
REQ-024 Commit when entry[head].busy && entry[head].done: at the edge, commit_valid=1 and commit_dest/tag/value take the head fields; entry busy=0, done=0; head+1; count-1. Otherwise commit_valid=0; the other commit outputs hold their last values.
REQ-025 Commit rate SHALL be at most one per cycle, strictly in allocation order.
REQ-026 Latency: a CDB write at edge N SHALL make the head eligible for the commit at edge N+1, so commit_valid is seen high in the cycle after edge N+1.
REQ-027 Simultaneous allocate and commit SHALL leave count unchanged; simultaneous CDB write to a newly allocated tag cannot occur and is not required to be handled.
REQ-028 dest=0 entries SHALL commit normally; the ARF discards writes to x0.
REQ-029 rd_ready and rd_value SHALL be combinational from entry[rd_tag]: rd_ready = busy && done. This path does not bypass a same-cycle CDB broadcast.
REQ-030 flush SHALL take priority over allocate, CDB and commit. At the edge, all busy/done bits, head, tail and count are cleared and commit_valid=0.
REQ-031 alloc_ready SHALL equal (count != DEPTH); count SHALL never exceed DEPTH or underflow.

Reset
REQ-032 While reset=1 at an edge: head=tail=count=0; every busy and done bit =0; commit_valid=0; commit_dest, commit_tag and commit_value =0. Entry dest and value need not be cleared.
REQ-033 Reset SHALL override flush and all other inputs. After reset: alloc_ready=1, alloc_tag=0, rd_ready=0.

Verification
REQ-034 Allocate dest 5, 6, 7 (tags 0, 1, 2); CDB tag2=0x33, then tag0=0x11, then tag1=0x22 -> commits in order (5,0x11), (6,0x22), (7,0x33) on consecutive cycles after the tag1 write.
REQ-035 Allocate 16 entries -> alloc_ready=0, count=16; a further alloc_valid is ignored; complete and commit head -> alloc_ready=1, alloc_tag=0 (wrap).
REQ-036 Wrap test: 40 allocate/complete/commit cycles with DEPTH=16 -> tags cycle 0..15 and commit values match a reference queue.
REQ-037 CDB to tag 3 while entry 3 is not busy -> no state change, no commit_valid.
REQ-038 Allocate 4 entries, complete 2, assert flush together with alloc_valid -> count=0, no commit, next alloc_tag=0.
REQ-039 Assert reset with 5 busy entries mid-run -> count=0, commit_valid=0, rd_ready=0 for all tags.

Source files
------------

// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - issue/CDB/operand/commit bundle of the reorder buffer
//
// Signal summary (slave = the ROB, master = issue/execute/retire side):
//   alloc_valid, alloc_dest  -> ROB   allocation request and its architectural destination
//   alloc_ready, alloc_tag   <- ROB   free entry available and tag the next allocation receives
//   cdb_valid, cdb_tag, cdb_value -> ROB   result broadcast
//   rd_tag -> ROB, rd_ready, rd_value <- ROB   operand lookup
//   commit_valid, commit_dest, commit_tag, commit_value <- ROB   retired entry
//   flush -> ROB   discard every in-flight entry
//   count <- ROB   occupied entries
interface rob_commit_unit_if #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
);
    logic             alloc_valid;
    logic [4:0]       alloc_dest;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_tag;

    logic             cdb_valid;
    logic [IDX_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;

    logic [IDX_W-1:0] rd_tag;
    logic             rd_ready;
    logic [XLEN-1:0]  rd_value;

    logic             commit_valid;
    logic [4:0]       commit_dest;
    logic [IDX_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_value;

    logic             flush;
    logic [IDX_W:0]   count;

    modport slave (
        input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_value, rd_tag, flush,
        output alloc_ready, alloc_tag, rd_ready, rd_value,
               commit_valid, commit_dest, commit_tag, commit_value, count
    );

    modport master (
        output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_value, rd_tag, flush,
        input  alloc_ready, alloc_tag, rd_ready, rd_value,
               commit_valid, commit_dest, commit_tag, commit_value, count
    );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - in-order reorder buffer with CDB completion and single-entry commit
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; overrides flush and every other input
//   rob    rob_commit_unit_if.slave: allocation, CDB write, operand lookup, commit, flush, count
//
// Circular buffer of DEPTH entries (busy, done, dest, value). Allocation writes the
// tail, the CDB marks an entry done, and the head retires once it is done, one entry
// per cycle in allocation order. Commit outputs are registered.
module rob_commit_unit #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic                clock,
    input  logic                reset,
    rob_commit_unit_if.slave    rob
);
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [4:0]       dest_mem  [DEPTH];
    logic [XLEN-1:0]  value_mem [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count_q;

    logic alloc_fire;
    logic cdb_fire;
    logic commit_fire;

    // Full blocks allocation outright; a commit in the same cycle does not free a slot early.
    assign rob.alloc_ready = (count_q != FULL_COUNT);
    assign rob.alloc_tag   = tail;
    assign rob.count       = count_q;

    assign alloc_fire  = rob.alloc_valid && rob.alloc_ready;
    assign cdb_fire    = rob.cdb_valid && busy[rob.cdb_tag];
    assign commit_fire = busy[head] && done[head];

    // Operand lookup reads stored state only; a same-cycle broadcast is not forwarded.
    assign rob.rd_ready = busy[rob.rd_tag] && done[rob.rd_tag];
    assign rob.rd_value = value_mem[rob.rd_tag];

    always_ff @(posedge clock) begin
        if (reset) begin
            head             <= '0;
            tail             <= '0;
            count_q          <= '0;
            busy             <= '0;
            done             <= '0;
            rob.commit_valid <= 1'b0;
            rob.commit_dest  <= '0;
            rob.commit_tag   <= '0;
            rob.commit_value <= '0;
        end else if (rob.flush) begin
            head             <= '0;
            tail             <= '0;
            count_q          <= '0;
            busy             <= '0;
            done             <= '0;
            rob.commit_valid <= 1'b0;
        end else begin
            rob.commit_valid <= commit_fire;
            if (commit_fire) begin
                rob.commit_dest  <= dest_mem[head];
                rob.commit_tag   <= head;
                rob.commit_value <= value_mem[head];
            end

            // Update order matters only on paper: the head being retired is already done,
            // and the tail is never the busy head while allocation is allowed.
            if (cdb_fire) begin
                done[rob.cdb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + 1'b1;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; busy/done qualify every read of it.
    always_ff @(posedge clock) begin
        if (!reset && !rob.flush) begin
            if (alloc_fire) begin
                dest_mem[tail] <= rob.alloc_dest;
            end
            if (cdb_fire) begin
                value_mem[rob.cdb_tag] <= rob.cdb_value;
            end
        end
    end
endmodule
